memory_access: RTL and testbench

- Pipeline stage directly upstream of writeback. It accepts one instruction at a time from execute and performs the data-memory access for loads and stores over a req/ack bus.
- It returns the load word right-aligned, so the selected byte or halfword sits at bit 0 for writeback's sign/zero extension.
- It forwards pc/opcode/rd/funct3/alu_res unchanged and holds a single-entry output register. It flags misaligned accesses and bus timeouts.

---
 rtl/memory_access_pkg.sv | 21 ++
 rtl/memory_access_if.sv | 15 +
 rtl/memory_access_lsu_align.sv | 38 +++
 rtl/memory_access.sv | 122 ++++++++++++
 tb/tb_memory_access.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// Shared encodings and FSM state type for the memory access pipeline stage.
package memory_access_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] BYTE   = 3'b000;
    localparam logic [2:0] HALF   = 3'b001;
    localparam logic [2:0] WORD   = 3'b010;
    localparam logic [2:0] BYTE_U = 3'b100;
    localparam logic [2:0] HALF_U = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory req/ack bus between the memory access stage and data memory.
interface memory_access_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);

endinterface

// File: rtl/memory_access_lsu_align.sv
// Byte-lane steering: alignment check, store strobes/data and load right-alignment.
module lsu_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    input  logic [1:0]  rdata_lo,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        misaligned = 1'b0;
        wstrb      = 4'b1111;
        wdata      = rs2;
        case (funct3[1:0])
            BYTE[1:0]: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            HALF[1:0]: begin
                misaligned = addr_lo[0];
                wstrb      = 4'b0011 << addr_lo;
                wdata      = {2{rs2[15:0]}};
            end
            WORD[1:0]: misaligned = |addr_lo;
            default: ;
        endcase
    end

    assign load_data = rdata >> {rdata_lo, 3'b000};

endmodule

// File: rtl/memory_access.sv
// Memory access stage: one instruction in flight, req/ack data bus, single-entry output register.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int TCW         = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_rs2,
    memory_access_if.master dmem,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_alu_res,
    output logic [31:0] out_mem_res,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [TCW-1:0] CNT_LAST = TCW'(ACK_TIMEOUT - 1);

    state_t         state, state_next;
    logic [TCW-1:0] cnt;
    logic           accept, go_wait, ack_hit, timeout;
    logic           align_mis;
    logic [3:0]     align_wstrb;
    logic [31:0]    align_wdata, load_data;

    // The load shift uses the captured address, which out_alu_res already holds.
    lsu_align u_align (
        .funct3     (in_funct3),
        .addr_lo    (in_alu_res[1:0]),
        .rs2        (in_rs2),
        .rdata      (dmem.rdata),
        .rdata_lo   (out_alu_res[1:0]),
        .misaligned (align_mis),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (load_data)
    );

    assign in_ready = (state != WAIT);

    always_comb begin
        accept     = in_valid && in_ready;
        go_wait    = accept && is_mem_op(in_opcode) && !align_mis;
        ack_hit    = (state == WAIT) && dmem.ack;
        timeout    = (state == WAIT) && !dmem.ack && (cnt == CNT_LAST);
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (go_wait ? WAIT : DONE) : IDLE;
            WAIT:       if (ack_hit || timeout) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            dmem.req    <= 1'b0;
            dmem.we     <= 1'b0;
            dmem.addr   <= '0;
            dmem.wdata  <= '0;
            dmem.wstrb  <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_opcode  <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_alu_res <= '0;
            out_mem_res <= '0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            out_valid  <= (state_next == DONE);
            misaligned <= accept && is_mem_op(in_opcode) && align_mis;
            bus_err    <= timeout;
            if (accept) begin
                out_pc      <= in_pc;
                out_opcode  <= in_opcode;
                out_rd      <= in_rd;
                out_funct3  <= in_funct3;
                out_alu_res <= in_alu_res;
                out_mem_res <= '0;
                cnt         <= '0;
                if (go_wait) begin
                    dmem.req   <= 1'b1;
                    dmem.we    <= (in_opcode == OP_STORE);
                    dmem.addr  <= {in_alu_res[31:2], 2'b00};
                    dmem.wdata <= align_wdata;
                    dmem.wstrb <= (in_opcode == OP_STORE) ? align_wstrb : 4'b0000;
                end
            end else if (state == WAIT) begin
                if (ack_hit) begin
                    dmem.req <= 1'b0;
                    if (out_opcode == OP_LOAD) out_mem_res <= load_data;
                end else if (timeout) begin
                    dmem.req <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized self-checking bench for memory_access against a byte-level memory model.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int         ACK_TIMEOUT = 4;
    localparam int         TCW         = 3;
    localparam logic [6:0] OP_ADD      = 7'b0110011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_res;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [31:0] out_alu_res;
    logic [31:0] out_mem_res;
    logic        misaligned;
    logic        bus_err;

    memory_access_if dmem ();

    memory_access #(.ACK_TIMEOUT(ACK_TIMEOUT), .TCW(TCW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_funct3   (in_funct3),
        .in_alu_res  (in_alu_res),
        .in_rs2      (in_rs2),
        .dmem        (dmem.master),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_funct3  (out_funct3),
        .out_alu_res (out_alu_res),
        .out_mem_res (out_mem_res),
        .misaligned  (misaligned),
        .bus_err     (bus_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-addressed reference memory and the word memory the bus slave serves.
    logic [7:0]  model_mem [64];
    logic [31:0] bus_mem   [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int widx, input logic [31:0] word);
        bus_mem[widx] = word;
        for (int b = 0; b < 4; b++) model_mem[widx*4 + b] = word[8*b +: 8];
    endtask

    // ack_at: WAIT cycle (1-based) on which the slave acks; beyond ACK_TIMEOUT means never.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int ack_at);
        logic [4:0]  rd      = 5'($urandom);
        logic [31:0] pc      = $urandom;
        bit          is_ld   = (op == OP_LOAD);
        bit          is_st   = (op == OP_STORE);
        int          size    = 1 << f3[1:0];
        bit          mis     = (is_ld || is_st) && ((int'(addr[2:0]) % size) != 0);
        bit          bus     = (is_ld || is_st) && !mis;
        bit          acked   = bus && (ack_at <= ACK_TIMEOUT);
        int          lo      = int'(addr[1:0]);
        int          widx    = int'(addr[5:2]);
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_res = '0;

        exp_strb  = is_st ? 4'(((1 << size) - 1) << lo) : 4'b0000;
        exp_wdata = (size == 1) ? {4{rs2[7:0]}} : (size == 2) ? {2{rs2[15:0]}} : rs2;

        @(negedge clock);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_opcode  = op;
        in_rd      = rd;
        in_funct3  = f3;
        in_alu_res = addr;
        in_rs2     = rs2;
        @(posedge clock);
        #1 in_valid = 1'b0;

        if (bus) begin
            for (int w = 1; w <= ACK_TIMEOUT; w++) begin
                @(negedge clock);
                check("wait_req", 32'(dmem.req), 32'd1);
                check("wait_ready", 32'(in_ready), 32'd0);
                check("wait_valid", 32'(out_valid), 32'd0);
                check("bus_addr", dmem.addr, addr & 32'hFFFF_FFFC);
                check("bus_we", 32'(dmem.we), 32'(is_st));
                check("bus_wstrb", 32'(dmem.wstrb), 32'(exp_strb));
                if (is_st) check("bus_wdata", dmem.wdata, exp_wdata);
                if (w == ack_at) begin
                    dmem.ack   = 1'b1;
                    dmem.rdata = is_ld ? bus_mem[dmem.addr[5:2]] : $urandom;
                    if (is_st)
                        for (int b = 0; b < 4; b++)
                            if (dmem.wstrb[b]) bus_mem[dmem.addr[5:2]][8*b +: 8] = dmem.wdata[8*b +: 8];
                    @(posedge clock);
                    #1 dmem.ack = 1'b0;
                    break;
                end
            end
        end

        if (acked && is_st)
            for (int k = 0; k < size; k++) model_mem[widx*4 + lo + k] = rs2[8*k +: 8];
        if (acked && is_ld)
            for (int k = 0; k < 4 - lo; k++) exp_res |= 32'(model_mem[widx*4 + lo + k]) << (8*k);

        @(negedge clock);
        check("done_valid", 32'(out_valid), 32'd1);
        check("done_misaligned", 32'(misaligned), 32'(mis));
        check("done_bus_err", 32'(bus_err), 32'(bus && !acked));
        check("done_req", 32'(dmem.req), 32'd0);
        check("done_pc", out_pc, pc);
        check("done_opcode", 32'(out_opcode), 32'(op));
        check("done_rd", 32'(out_rd), 32'(rd));
        check("done_funct3", 32'(out_funct3), 32'(f3));
        check("done_alu_res", out_alu_res, addr);
        check("done_mem_res", out_mem_res, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b [5];
        logic [2:0]  ld_f3 [5];

        in_valid   = 1'b0;
        in_pc      = '0;
        in_opcode  = '0;
        in_rd      = '0;
        in_funct3  = '0;
        in_alu_res = '0;
        in_rs2     = '0;
        dmem.ack   = 1'b0;
        dmem.rdata = '0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);

        repeat (3) @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_req", 32'(dmem.req), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_alu_res", out_alu_res, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b1;

        // Directed cases.
        run_op(OP_ADD, 3'b000, 32'h0000_0010, 32'h0, 0);
        run_op(OP_STORE, BYTE, 32'h0000_1003, 32'h0000_00AB, 3);
        preload(0, 32'h8001_1234);
        run_op(OP_LOAD, HALF, 32'h0000_2002, 32'h0, 2);
        check("lh_const", out_mem_res, 32'h0000_8001);
        run_op(OP_LOAD, WORD, 32'h0000_2000, 32'h0, 1);
        check("lw_const", out_mem_res, 32'h8001_1234);
        run_op(OP_LOAD, WORD, 32'h0000_3001, 32'h0, 1);
        run_op(OP_LOAD, WORD, 32'h0000_1004, 32'h0, ACK_TIMEOUT + 5);
        run_op(OP_STORE, WORD, 32'h0000_1008, 32'h1234_5678, ACK_TIMEOUT);

        // Stray ack while idle after a timeout must not produce output.
        run_op(OP_LOAD, HALF, 32'h0000_100A, 32'h0, ACK_TIMEOUT + 1);
        @(negedge clock);
        dmem.ack = 1'b1;
        @(negedge clock);
        dmem.ack = 1'b0;
        check("stray_valid", 32'(out_valid), 32'd0);
        check("stray_req", 32'(dmem.req), 32'd0);

        // Back-to-back non-memory ops: one result per cycle.
        for (int i = 0; i < 5; i++) b2b[i] = $urandom;
        @(negedge clock);
        in_valid   = 1'b1;
        in_opcode  = OP_ADD;
        in_alu_res = b2b[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_alu_res", out_alu_res, b2b[i]);
            check("b2b_req", 32'(dmem.req), 32'd0);
            if (i < 4) in_alu_res = b2b[i+1];
            else       in_valid = 1'b0;
        end
        @(negedge clock);
        check("b2b_end_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of WAIT.
        in_valid   = 1'b1;
        in_opcode  = OP_LOAD;
        in_funct3  = WORD;
        in_alu_res = 32'h0000_1004;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("prerst_req", 32'(dmem.req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_req", 32'(dmem.req), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_req", 32'(dmem.req), 32'd0);

        // Randomized mix of loads, stores and non-memory ops.
        ld_f3 = '{BYTE, HALF, WORD, BYTE_U, HALF_U};
        for (int n = 0; n < 120; n++) begin
            int          kind = $urandom_range(0, 4);
            logic [31:0] addr = 32'h0000_1000 + 32'($urandom_range(0, 63));
            int          ack  = $urandom_range(1, ACK_TIMEOUT + 1);
            case (kind)
                0, 1:    run_op(OP_LOAD, ld_f3[$urandom_range(0, 4)], addr, $urandom, ack);
                2:       run_op(OP_STORE, 3'($urandom_range(0, 2)), addr, $urandom, ack);
                3:       run_op(OP_JAL, 3'($urandom), $urandom, $urandom, ack);
                default: run_op(OP_ADD, 3'($urandom), $urandom, $urandom, ack);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
